// File: rtl/modulo_busca_instrucao.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and hands
// fetched words to decode over a valid/ready handshake, with redirect and halt.
module modulo_busca_instrucao #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] addr_mem,
    input  logic [DATA_WIDTH-1:0] instr_mem,
    input  logic                  dec_pronto,
    input  logic                  desvio_en,
    input  logic [ADDR_WIDTH-1:0] desvio_alvo,
    input  logic                  halt,
    input  logic                  retomar,
    output logic                  valido,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] pc_mais_um,
    output logic                  parado,
    output logic [31:0]           contador_instr
);

    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        PARADO = 2'd2
    } estado_t;

    estado_t               estado;
    estado_t               estado_n;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_n;
    logic                  valido_n;
    logic [DATA_WIDTH-1:0] instr_n;
    logic [ADDR_WIDTH-1:0] pc_out_n;
    logic                  parado_n;
    logic [CNT_WIDTH-1:0]  contador_n;
    logic                  avanca;
    logic                  aceita;

    assign addr_mem   = pc;
    assign pc_mais_um = pc_out + ADDR_WIDTH'(1);
    assign avanca     = !valido || dec_pronto;
    assign aceita     = valido && dec_pronto;

    // Next-state and next-register values; redirect beats halt beats advance.
    always_comb begin
        estado_n   = estado;
        pc_n       = pc;
        valido_n   = valido;
        instr_n    = instr_out;
        pc_out_n   = pc_out;
        contador_n = contador_instr + CNT_WIDTH'(aceita);

        unique case (estado)
            INICIO: begin
                valido_n = 1'b0;
                estado_n = BUSCA;
            end
            BUSCA: begin
                if (desvio_en) begin
                    pc_n     = desvio_alvo;
                    valido_n = 1'b0;
                    if (halt) begin
                        estado_n = PARADO;
                    end
                end else if (halt) begin
                    valido_n = 1'b0;
                    estado_n = PARADO;
                end else if (avanca) begin
                    instr_n  = instr_mem;
                    pc_out_n = pc;
                    valido_n = 1'b1;
                    pc_n     = pc + ADDR_WIDTH'(1);
                end
            end
            PARADO: begin
                valido_n = 1'b0;
                if (retomar) begin
                    estado_n = BUSCA;
                end
            end
            default: begin
                valido_n = 1'b0;
                estado_n = INICIO;
            end
        endcase

        parado_n = (estado_n == PARADO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= INICIO;
            pc             <= RESET_PC;
            valido         <= 1'b0;
            instr_out      <= '0;
            pc_out         <= '0;
            parado         <= 1'b0;
            contador_instr <= '0;
        end else begin
            estado         <= estado_n;
            pc             <= pc_n;
            valido         <= valido_n;
            instr_out      <= instr_n;
            pc_out         <= pc_out_n;
            parado         <= parado_n;
            contador_instr <= contador_n;
        end
    end

endmodule

// File: tb/tb_modulo_busca_instrucao.sv
// Bench for the fetch stage: directed scenarios plus a random run against a reference model.
module tb_modulo_busca_instrucao;

    logic        clk;
    logic        reset;
    logic        dec_pronto;
    logic        desvio_en;
    logic [12:0] desvio_alvo;
    logic        halt;
    logic        retomar;

    logic [12:0] addr_mem, pc_out, pc_mais_um;
    logic [31:0] instr_mem, instr_out, contador_instr;
    logic        valido, parado;

    logic [12:0] addr_mem_w, pc_out_w, pc_mais_um_w;
    logic [31:0] instr_mem_w, instr_out_w, contador_instr_w;
    logic        valido_w, parado_w;

    logic [31:0] rom [0:8191];
    int          n_checks;
    int          n_fail;

    assign instr_mem   = rom[addr_mem];
    assign instr_mem_w = rom[addr_mem_w];

    modulo_busca_instrucao #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .RESET_PC(13'h0000)) dut (
        .clk(clk), .reset(reset), .addr_mem(addr_mem), .instr_mem(instr_mem),
        .dec_pronto(dec_pronto), .desvio_en(desvio_en), .desvio_alvo(desvio_alvo),
        .halt(halt), .retomar(retomar), .valido(valido), .instr_out(instr_out),
        .pc_out(pc_out), .pc_mais_um(pc_mais_um), .parado(parado),
        .contador_instr(contador_instr)
    );

    modulo_busca_instrucao #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .RESET_PC(13'h1FFE)) dut_w (
        .clk(clk), .reset(reset), .addr_mem(addr_mem_w), .instr_mem(instr_mem_w),
        .dec_pronto(dec_pronto), .desvio_en(desvio_en), .desvio_alvo(desvio_alvo),
        .halt(halt), .retomar(retomar), .valido(valido_w), .instr_out(instr_out_w),
        .pc_out(pc_out_w), .pc_mais_um(pc_mais_um_w), .parado(parado_w),
        .contador_instr(contador_instr_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_pronto  = 1'b0;
        desvio_en   = 1'b0;
        desvio_alvo = '0;
        halt        = 1'b0;
        retomar     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        n_checks++; if (valido !== 1'b0) begin n_fail++; $display("FAIL reset_valido got=%b exp=0", valido); end
        n_checks++; if (instr_out !== 32'd0 || pc_out !== 13'd0) begin n_fail++; $display("FAIL reset_regs instr=%h pc_out=%h exp=0/0", instr_out, pc_out); end
        n_checks++; if (contador_instr !== 32'd0 || parado !== 1'b0) begin n_fail++; $display("FAIL reset_cnt cnt=%0d parado=%b exp=0/0", contador_instr, parado); end
        n_checks++; if (addr_mem !== 13'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr_mem); end
        reset = 1'b0;
        dec_pronto = 1'b1;
        tick();
        n_checks++; if (valido !== 1'b0) begin n_fail++; $display("FAIL settle_valido got=%b exp=0", valido); end
        tick();
        n_checks++; if (valido !== 1'b1 || instr_out !== rom[0] || pc_out !== 13'd0) begin
            n_fail++; $display("FAIL first_fetch v=%b instr=%h pc_out=%h exp=1/%h/0", valido, instr_out, pc_out, rom[0]);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (pc_out !== 13'(k) || instr_out !== rom[k] || contador_instr !== 32'(k)) begin
                n_fail++; $display("FAIL seq_%0d pc_out=%h instr=%h cnt=%0d exp=%h/%h/%0d", k, pc_out, instr_out, contador_instr, k, rom[k], k);
            end
            tick();
        end
        n_checks++; if (contador_instr !== 32'd4 || pc_out !== 13'd4) begin n_fail++; $display("FAIL seq_count cnt=%0d pc_out=%h exp=4/4", contador_instr, pc_out); end
    endtask

    task automatic test_stall();
        tick();
        dec_pronto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (valido !== 1'b1 || instr_out !== rom[5] || pc_out !== 13'd5 || addr_mem !== 13'd6 || contador_instr !== 32'd5) begin
                n_fail++; $display("FAIL stall_%0d v=%b instr=%h pc_out=%h addr=%h cnt=%0d exp=1/%h/5/6/5", k, valido, instr_out, pc_out, addr_mem, contador_instr, rom[5]);
            end
        end
        dec_pronto = 1'b1;
        tick();
        n_checks++; if (pc_out !== 13'd6 || instr_out !== rom[6] || contador_instr !== 32'd6) begin
            n_fail++; $display("FAIL stall_resume pc_out=%h instr=%h cnt=%0d exp=6/%h/6", pc_out, instr_out, contador_instr, rom[6]);
        end
        tick();
    endtask

    task automatic test_desvio();
        n_checks++; if (pc_out !== 13'd7 || valido !== 1'b1) begin n_fail++; $display("FAIL pre_desvio pc_out=%h v=%b exp=7/1", pc_out, valido); end
        dec_pronto  = 1'b0;
        desvio_en   = 1'b1;
        desvio_alvo = 13'h100;
        tick();
        n_checks++; if (valido !== 1'b0 || addr_mem !== 13'h100 || contador_instr !== 32'd7) begin
            n_fail++; $display("FAIL desvio_flush v=%b addr=%h cnt=%0d exp=0/100/7", valido, addr_mem, contador_instr);
        end
        desvio_en  = 1'b0;
        dec_pronto = 1'b1;
        tick();
        n_checks++; if (valido !== 1'b1 || pc_out !== 13'h100 || instr_out !== rom[13'h100] || pc_mais_um !== 13'h101) begin
            n_fail++; $display("FAIL desvio_target v=%b pc_out=%h instr=%h link=%h exp=1/100/%h/101", valido, pc_out, instr_out, pc_mais_um, rom[13'h100]);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (valido_w !== 1'b1 || pc_out_w !== 13'h1FFE || pc_mais_um_w !== 13'h1FFF) begin
            n_fail++; $display("FAIL wrap_0 v=%b pc_out=%h link=%h exp=1/1ffe/1fff", valido_w, pc_out_w, pc_mais_um_w);
        end
        tick();
        n_checks++; if (pc_out_w !== 13'h1FFF || pc_mais_um_w !== 13'h0000 || addr_mem_w !== 13'h0000) begin
            n_fail++; $display("FAIL wrap_1 pc_out=%h link=%h addr=%h exp=1fff/0/0", pc_out_w, pc_mais_um_w, addr_mem_w);
        end
        tick();
        n_checks++; if (pc_out_w !== 13'h0000 || instr_out_w !== rom[0]) begin
            n_fail++; $display("FAIL wrap_2 pc_out=%h instr=%h exp=0/%h", pc_out_w, instr_out_w, rom[0]);
        end
    endtask

    task automatic test_halt_desvio();
        halt        = 1'b1;
        desvio_en   = 1'b1;
        desvio_alvo = 13'h40;
        tick();
        halt        = 1'b1;
        desvio_alvo = 13'h77;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (parado !== 1'b1 || valido !== 1'b0 || addr_mem !== 13'h40) begin
                n_fail++; $display("FAIL halted_%0d parado=%b v=%b addr=%h exp=1/0/40", k, parado, valido, addr_mem);
            end
            tick();
        end
        halt      = 1'b0;
        desvio_en = 1'b0;
        retomar   = 1'b1;
        tick();
        retomar = 1'b0;
        n_checks++; if (parado !== 1'b0 || valido !== 1'b0) begin n_fail++; $display("FAIL resume_0 parado=%b v=%b exp=0/0", parado, valido); end
        tick();
        n_checks++; if (valido !== 1'b1 || instr_out !== rom[13'h40] || pc_out !== 13'h40) begin
            n_fail++; $display("FAIL resume_1 v=%b instr=%h pc_out=%h exp=1/%h/40", valido, instr_out, pc_out, rom[13'h40]);
        end
    endtask

    task automatic test_reset_mid();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++; if (parado !== 1'b1) begin n_fail++; $display("FAIL pre_reset_halt parado=%b exp=1", parado); end
        reset       = 1'b1;
        desvio_en   = 1'b1;
        desvio_alvo = 13'h555;
        tick();
        desvio_en = 1'b0;
        n_checks++; if (parado !== 1'b0 || valido !== 1'b0 || pc_out !== 13'd0 || instr_out !== 32'd0 || contador_instr !== 32'd0 || addr_mem !== 13'd0) begin
            n_fail++; $display("FAIL reset_in_halt parado=%b v=%b pc_out=%h instr=%h cnt=%0d addr=%h exp=all 0", parado, valido, pc_out, instr_out, contador_instr, addr_mem);
        end
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (valido !== 1'b1 || pc_out !== 13'd0 || instr_out !== rom[0]) begin
            n_fail++; $display("FAIL refetch_halt v=%b pc_out=%h instr=%h exp=1/0/%h", valido, pc_out, instr_out, rom[0]);
        end
        dec_pronto = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (valido !== 1'b0 || pc_out !== 13'd0 || instr_out !== 32'd0 || contador_instr !== 32'd0) begin
            n_fail++; $display("FAIL reset_in_stall v=%b pc_out=%h instr=%h cnt=%0d exp=0/0/0/0", valido, pc_out, instr_out, contador_instr);
        end
        reset      = 1'b0;
        dec_pronto = 1'b1;
        tick();
        tick();
        n_checks++; if (valido !== 1'b1 || pc_out !== 13'd0 || instr_out !== rom[0]) begin
            n_fail++; $display("FAIL refetch_stall v=%b pc_out=%h instr=%h exp=1/0/%h", valido, pc_out, instr_out, rom[0]);
        end
    endtask

    // Reference model: tracks the next fetch address, the word handed to decode and the counter.
    task automatic test_random();
        logic [12:0] m_pc, m_pco;
        logic [31:0] m_instr, m_cnt;
        logic        m_v, m_settling, m_halted, hs;
        int          errs;
        errs = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        m_pc       = 13'd0;
        m_pco      = 13'd0;
        m_instr    = 32'd0;
        m_cnt      = 32'd0;
        m_v        = 1'b0;
        m_settling = 1'b1;
        m_halted   = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dec_pronto  = ($urandom_range(0, 3) != 0);
            desvio_en   = ($urandom_range(0, 15) == 0);
            desvio_alvo = 13'($urandom);
            halt        = ($urandom_range(0, 19) == 0);
            retomar     = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            hs = m_v && dec_pronto;
            if (m_settling) begin
                m_settling = 1'b0;
            end else if (m_halted) begin
                if (retomar) m_halted = 1'b0;
            end else if (desvio_en) begin
                m_pc = desvio_alvo;
                m_v  = 1'b0;
                if (halt) m_halted = 1'b1;
            end else if (halt) begin
                m_v      = 1'b0;
                m_halted = 1'b1;
            end else if (!m_v || dec_pronto) begin
                m_instr = rom[m_pc];
                m_pco   = m_pc;
                m_v     = 1'b1;
                m_pc    = m_pc + 13'd1;
            end
            m_cnt = m_cnt + 32'(hs);
            #1;
            n_checks++;
            if (valido !== m_v || parado !== m_halted || addr_mem !== m_pc || pc_out !== m_pco ||
                instr_out !== m_instr || pc_mais_um !== 13'(m_pco + 13'd1) || contador_instr !== m_cnt) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cyc%0d v=%b/%b parado=%b/%b addr=%h/%h pc_out=%h/%h instr=%h/%h cnt=%0d/%0d (got/exp)",
                             cyc, valido, m_v, parado, m_halted, addr_mem, m_pc, pc_out, m_pco, instr_out, m_instr, contador_instr, m_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 8192; i++) rom[i] = $urandom;
        test_reset();
        test_sequential();
        test_stall();
        test_desvio();
        test_wrap();
        test_halt_desvio();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
